// File: rtl/lb_rd_sched_pkg.sv
// Shared types for the line-buffer read scheduler.
//   NBANK      : number of line-buffer banks
//   bank_idx_t : bank index (wraps mod 4)
//   rd_state_t : read scheduler FSM states
//   bank_add   : bank index arithmetic mod 4
package lb_pkg;

  localparam int unsigned NBANK = 4;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SWEEP,
    DRAIN,
    RELEASE,
    DONE
  } rd_state_t;

  function automatic bank_idx_t bank_add(bank_idx_t b, int n);
    return bank_idx_t'((int'(b) + n) & 3);
  endfunction

endpackage

// File: rtl/lb_rd_sched_skid.sv
// Two-entry skid FIFO that absorbs bank read data returning one cycle
// after issue, so the window stream can stall without losing beats.
// Ports:
//   clk, rst  : clock, async active-high reset (flushes the FIFO)
//   i_push    : write i_din this cycle
//   i_pop     : consume the head entry this cycle
//   i_din     : entry to write
//   o_dout    : head entry
//   o_occ     : number of valid entries (0..2)
module rd_skid_fifo #(
  parameter int unsigned DW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic [1:0]    o_occ
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_occ;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_dout = r_mem[r_rd];
  assign o_occ  = r_occ;

endmodule

// File: rtl/lb_rd_sched.sv
// Read scheduler for the 4-bank line-buffer memory. Rotates a 3-row window
// over the banks, sweeps column addresses and streams one 3-pixel column per
// beat on a valid/ready interface, releasing each consumed bank via mem_used.
// Optional build macro: LB_RD_STATS_EN adds stall_cnt / wait_cnt outputs.
// Ports:
//   clk, rst       : clock, async active-high reset
//   start          : 1-cycle pulse; samples cfg_* and begins a frame
//   cfg_width      : pixels per row (W)
//   cfg_height     : rows per frame (H)
//   mem_bank_full  : bank[i] holds a complete row
//   pix_data[3:0]  : per-bank read data, 1 cycle after mb_rd_addr
//   mem_used       : 1-cycle release pulse per bank
//   mb_rd_addr[3:0]: per-bank read address
//   win_data       : {row2,row1,row0}, row0 = oldest
//   win_valid/win_ready : output handshake
//   win_last_x     : beat is column W-1
//   win_last_y     : beat is in output row H-3
//   done           : high after the final beat until next start
//   stall_cnt      : (LB_RD_STATS_EN) cycles with win_valid && !win_ready
//   wait_cnt       : (LB_RD_STATS_EN) cycles spent in WAIT
module lb_rd_sched
  import lb_pkg::*;
#(
  parameter int unsigned XB = 10,
  parameter int unsigned YB = 10,
  parameter int unsigned PB = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XB-1:0]   cfg_width,
  input  logic [YB-1:0]   cfg_height,
  input  logic [3:0]      mem_bank_full,
  input  logic [PB-1:0]   pix_data [3:0],
  output logic [3:0]      mem_used,
  output logic [XB-1:0]   mb_rd_addr [3:0],
  output logic [3*PB-1:0] win_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic            win_last_x,
  output logic            win_last_y,
  output logic            done
`ifdef LB_RD_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     wait_cnt
`endif
);

  localparam int unsigned DW = 3 * PB + 2;

  rd_state_t     r_state;
  rd_state_t     w_next;
  bank_idx_t     r_base;
  logic [YB-1:0] r_row;
  logic [XB-1:0] r_x;
  logic [XB-1:0] r_w;
  logic [YB-1:0] r_h;
  logic          r_inflight;
  logic          r_tag_x;
  logic          r_tag_y;
  logic [XB-1:0] r_addr [3:0];

  logic          w_start_ok;
  logic          w_degen;
  logic          w_rows_full;
  logic          w_pop;
  logic [2:0]    w_level;
  logic          w_issue;
  logic          w_x_last;
  logic          w_row_last;
  logic          w_more_rows;
  logic [1:0]    w_occ;
  logic [DW-1:0] w_fifo_din;
  logic [DW-1:0] w_fifo_dout;

  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_degen     = (cfg_width == '0) || (cfg_height < YB'(3));
  assign w_rows_full = mem_bank_full[r_base]
                     & mem_bank_full[bank_add(r_base, 1)]
                     & mem_bank_full[bank_add(r_base, 2)];
  assign w_x_last    = (r_x == r_w - XB'(1));
  assign w_row_last  = (r_row == r_h - YB'(3));
  // row+1 < H-2, rearranged to avoid underflow
  assign w_more_rows = ({1'b0, r_row} + (YB+1)'(3)) < {1'b0, r_h};

  assign win_valid = (w_occ != 2'd0);
  assign w_pop     = win_valid && win_ready;

  // Entries already committed to the FIFO after this cycle's pop; the read
  // issued now lands next cycle, so at most one slot may be spoken for.
  assign w_level = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = (r_state == SWEEP) && (w_level < 3'd2);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = w_degen ? DONE : WAIT;
      WAIT:       if (w_rows_full) w_next = SWEEP;
      SWEEP:      if (w_issue && w_x_last) w_next = DRAIN;
      DRAIN:      if ((w_occ == 2'd0) && !r_inflight) w_next = RELEASE;
      RELEASE:    w_next = w_more_rows ? WAIT : DONE;
      default:    w_next = IDLE;
    endcase
  end

  // The address is presented combinationally in the issue cycle so data
  // returns one cycle later; the idle bank keeps its last address.
  always_comb begin : addr_mux
    bank_idx_t v_off;
    for (int unsigned b = 0; b < NBANK; b++) begin
      v_off = bank_idx_t'(b) - r_base;
      mb_rd_addr[b] = (w_issue && (v_off != 2'd3)) ? r_x : r_addr[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_row      <= '0;
      r_x        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_inflight <= 1'b0;
      r_tag_x    <= 1'b0;
      r_tag_y    <= 1'b0;
      for (int unsigned b = 0; b < NBANK; b++) r_addr[b] <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      for (int unsigned b = 0; b < NBANK; b++) r_addr[b] <= mb_rd_addr[b];
      if (w_start_ok) begin
        r_w   <= cfg_width;
        r_h   <= cfg_height;
        r_row <= '0;
        r_x   <= '0;
      end
      if (w_issue) begin
        r_x     <= r_x + XB'(1);
        r_tag_x <= w_x_last;
        r_tag_y <= w_row_last;
      end
      if (r_state == RELEASE) begin
        r_base <= bank_add(r_base, 1);
        r_row  <= r_row + YB'(1);
        r_x    <= '0;
      end
    end
  end

  assign w_fifo_din = {r_tag_y, r_tag_x,
                       pix_data[bank_add(r_base, 2)],
                       pix_data[bank_add(r_base, 1)],
                       pix_data[r_base]};

  rd_skid_fifo #(.DW(DW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_pop  (w_pop),
    .i_din  (w_fifo_din),
    .o_dout (w_fifo_dout),
    .o_occ  (w_occ)
  );

  assign win_data   = w_fifo_dout[3*PB-1:0];
  assign win_last_x = win_valid && w_fifo_dout[3*PB];
  assign win_last_y = win_valid && w_fifo_dout[3*PB+1];
  assign mem_used   = (r_state == RELEASE) ? (4'b0001 << r_base) : '0;
  assign done       = (r_state == DONE);

`ifdef LB_RD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (win_valid && !win_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if ((r_state == WAIT) && (r_wait_cnt != '1)) r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign wait_cnt  = r_wait_cnt;
`endif

endmodule
